mix_cols_engine: RTL and testbench
==================================

# mix_cols_engine

Sequential, parametrised AES MixColumns engine supporting forward, inverse and bypass modes on a full 128-bit state. It sits between the ShiftRows and AddRoundKey stages of the iterative AES datapath and exchanges states with its neighbours over valid/ready handshakes. It processes COLS_PER_CYCLE state columns per clock to trade area against latency.

## Interface
- COLS_PER_CYCLE, 1: columns transformed per BUSY cycle. Legal values are 1, 2 and 4; any other value is an elaboration error.
- clk  in  1  single clock; all flops update on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  in_data and in_mode are valid.
- in_ready  out  1  engine can accept a state; equals (state==IDLE).
- in_data  in  128  input state. Byte s[r][c] = in_data[127-8*(4c+r) -: 8] (FIPS-197 column-major order).
- in_mode  in  2  operation select: 0 = forward, 1 = inverse, 2 = bypass, 3 = reserved (treated as bypass).
- out_valid  out  1  out_data holds a finished state.
- out_ready  in  1  downstream accepts out_data.
- out_data  out  128  result state, same byte mapping as in_data.

## Operation
- GF(2^8) reduction polynomial is 0x11B. xtime(b) = (b<<1) ^ (b[7] ? 0x1B : 0).
- Forward transform, per column: o0=2a0^3a1^a2^a3, o1=a0^2a1^3a2^a3, o2=a0^a1^2a2^3a3, o3=3a0^a1^a2^2a3.
- Inverse transform: same structure using coefficient rows {0E,0B,0D,09}, each rotated right by one byte per output row. Multiplications by 9, B, D and E are built from xtime chains plus XOR. No lookup tables.
- N = 4/COLS_PER_CYCLE. Column counter col_idx has width max(1, log2 N) and wraps to 0 after the last group.
- States:
  - IDLE: in_ready=1. On in_valid, latch in_data into the work register and latch the mode. Go to DONE if the mode is bypass; otherwise clear col_idx and go to BUSY.
  - BUSY: each cycle, transform columns col_idx*CPC .. col_idx*CPC+CPC-1 of the work register and write them in place; then col_idx++. When the last group is written, go to DONE.
  - DONE: out_valid=1 and out_data = work register. On out_ready, go to IDLE.
- Mode is latched at acceptance; in_mode changes during BUSY or DONE are ignored.
- In DONE, in_ready=0 even while out_ready=1. A simultaneous in_valid is not accepted and must be re-presented in IDLE.
- Columns not yet processed in BUSY hold their input values. out_data is don't-care when out_valid=0 but must not glitch in DONE.

## Timing
- Reset values: state=IDLE, in_ready=1 in the cycle after reset, out_valid=0, out_data=0, col_idx=0, latched mode=0.
- A rst asserted in any state (including mid-BUSY or in DONE with out_ready low) discards the state in flight; the next cycle is IDLE with reset values.
- Forward/inverse latency: acceptance edge to out_valid high is N+1 edges (5 for CPC=1, 3 for CPC=2, 2 for CPC=4). Bypass latency is 1 edge.
- Throughput with out_ready tied high: one state every N+2 cycles (bypass: every 2 cycles).
- out_data and out_valid are driven directly from flops; there is no combinational path from the inputs to the outputs. in_ready depends only on state.
- Backpressure: in DONE, out_valid and out_data stay stable indefinitely until out_ready is seen.

## Test plan
- Forward, CPC=1: columns db135345, f20a225c, 01010101, d4d4d4d5 -> out 8e4da1bc, 9fdc589d, 01010101, d5d5d7d6. out_valid rises exactly 5 edges after acceptance.
- Inverse, CPC=4: the forward output above -> the original input is returned. Latency is 2 edges. Sweep CPC=2 and confirm the identical result with latency 3.
- Bypass and reserved mode: in_data=00112233445566778899aabbccddeeff, mode=2 then mode=3 -> out_data equals in_data, latency 1 edge, BUSY is never entered.
- Backpressure: hold out_ready=0 for 10 cycles in DONE while in_valid=1 with new data -> out_data is stable, in_ready=0, and the new data is accepted only in the cycle after out_ready=1 returns the engine to IDLE.
- Reset mid-BUSY: assert rst on the second BUSY cycle (CPC=1) -> next cycle out_valid=0, out_data=0, in_ready=1. A following fresh state produces the correct result.
- Random: 1000 random states with random modes, random CPC builds and random in_valid/out_ready stalls -> results match the reference model and inverse(forward(x)) = x.

Source files
------------

// File: rtl/mix_cols_engine.sv
// mix_cols_engine: sequential AES MixColumns (forward/inverse/bypass), COLS_PER_CYCLE columns per cycle
module mix_cols_engine #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic [1:0]   in_mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);
  localparam int N = 4 / COLS_PER_CYCLE;
  localparam int CW = N > 1 ? $clog2(N) : 1;
  if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cpc
    $error("mix_cols_engine: COLS_PER_CYCLE must be 1, 2 or 4");
  end
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_nx;
  logic [127:0] work, work_nx;
  logic [1:0] mode;
  logic [CW-1:0] col_idx;
  logic last;
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] m9(input logic [7:0] b);
    return xt(xt(xt(b))) ^ b;
  endfunction
  function automatic logic [7:0] mb(input logic [7:0] b);
    return xt(xt(xt(b))) ^ xt(b) ^ b;
  endfunction
  function automatic logic [7:0] md(input logic [7:0] b);
    return xt(xt(xt(b))) ^ xt(xt(b)) ^ b;
  endfunction
  function automatic logic [7:0] me(input logic [7:0] b);
    return xt(xt(xt(b))) ^ xt(xt(b)) ^ xt(b);
  endfunction
  function automatic logic [31:0] mix(input logic [31:0] c, input logic inv);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return inv ? {me(a0) ^ mb(a1) ^ md(a2) ^ m9(a3),
                  m9(a0) ^ me(a1) ^ mb(a2) ^ md(a3),
                  md(a0) ^ m9(a1) ^ me(a2) ^ mb(a3),
                  mb(a0) ^ md(a1) ^ m9(a2) ^ me(a3)}
               : {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                  a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                  a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                  xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
  endfunction
  assign last = col_idx == CW'(N - 1);
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  assign out_data = work;
  always_comb begin
    work_nx = work;
    for (int j = 0; j < COLS_PER_CYCLE; j++)
      work_nx[127 - 32 * (int'(col_idx) * COLS_PER_CYCLE + j) -: 32] =
        mix(work[127 - 32 * (int'(col_idx) * COLS_PER_CYCLE + j) -: 32], mode == 2'd1);
  end
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (in_valid) state_nx = in_mode[1] ? DONE : BUSY;
      BUSY: if (last) state_nx = DONE;
      DONE: if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) state <= rst ? IDLE : state_nx;
  always_ff @(posedge clk) begin
    if (rst) begin
      work <= '0;
      mode <= '0;
      col_idx <= '0;
    end else if (state == IDLE && in_valid) begin
      work <= in_data;
      mode <= in_mode;
      col_idx <= '0;
    end else if (state == BUSY) begin
      work <= work_nx;
      col_idx <= last ? '0 : col_idx + 1'b1;
    end
  end
endmodule

// File: tb/tb_mix_cols_engine.sv
// tb_mix_cols_engine: randomized check of three CPC builds against a matrix-level GF(2^8) model
module tb_mix_cols_engine;
  logic clk = 0;
  logic rst;
  logic [2:0] in_valid, in_ready, out_valid, out_ready;
  logic [2:0][127:0] in_data, out_data;
  logic [2:0][1:0] in_mode;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  mix_cols_engine #(.COLS_PER_CYCLE(1)) u_c1 (.clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data[0]), .in_mode(in_mode[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]));
  mix_cols_engine #(.COLS_PER_CYCLE(2)) u_c2 (.clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data[1]), .in_mode(in_mode[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]));
  mix_cols_engine #(.COLS_PER_CYCLE(4)) u_c4 (.clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_data(in_data[2]), .in_mode(in_mode[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_data(out_data[2]));
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 0;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction
  function automatic logic [127:0] model(input logic [127:0] d, input logic [1:0] m);
    logic [7:0] fb [4] = '{8'h02, 8'h03, 8'h01, 8'h01};
    logic [7:0] ib [4] = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    logic [7:0] s [4][4];
    logic [127:0] o = '0;
    if (m[1]) return d;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) s[r][c] = d[127 - 8 * (4 * c + r) -: 8];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        logic [7:0] acc = 0;
        for (int k = 0; k < 4; k++) acc ^= gmul(m[0] ? ib[(k - r + 4) % 4] : fb[(k - r + 4) % 4], s[k][c]);
        o[127 - 8 * (4 * c + r) -: 8] = acc;
      end
    return o;
  endfunction
  task automatic release_out(input int k);
    out_ready[k] = 1;
    @(negedge clk);
    out_ready[k] = 0;
  endtask
  task automatic wait_out(input int k, inout int lat);
    while (!out_valid[k] && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid[k]) check("out_valid_timeout", 128'(out_valid[k]), 128'(1));
  endtask
  task automatic xfer(input int k, input logic [127:0] d, input logic [1:0] m, input int maxstall,
                      output logic [127:0] r, output int lat);
    int g = 0;
    repeat ($urandom_range(0, maxstall)) @(negedge clk);
    in_valid[k] = 1; in_data[k] = d; in_mode[k] = m;
    while (!in_ready[k] && g < 40) begin
      @(negedge clk);
      g++;
    end
    if (!in_ready[k]) check("in_ready_timeout", 128'(in_ready[k]), 128'(1));
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    in_valid[k] = 0; in_mode[k] = 2'($urandom); in_data[k] = {$urandom, $urandom, $urandom, $urandom};
    wait_out(k, lat);
    r = out_data[k];
    repeat ($urandom_range(0, maxstall)) begin
      @(negedge clk);
      check("stall_data", out_data[k], r);
      check("stall_ready", 128'(in_ready[k]), 128'(0));
    end
    release_out(k);
  endtask
  localparam logic [127:0] VIN = 128'hdb135345_f20a225c_01010101_d4d4d4d5;
  localparam logic [127:0] VOUT = 128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6;
  localparam logic [127:0] BYP = 128'h00112233445566778899aabbccddeeff;
  initial begin
    logic [127:0] r, r2, d1, d2;
    int lat;
    rst = 1; in_valid = '0; out_ready = '0; in_data = '0; in_mode = '0;
    repeat (3) @(negedge clk);
    rst = 0;
    for (int k = 0; k < 3; k++) begin
      check("rst_in_ready", 128'(in_ready[k]), 128'(1));
      check("rst_out_valid", 128'(out_valid[k]), 128'(0));
      check("rst_out_data", out_data[k], '0);
    end
    xfer(0, VIN, 2'd0, 0, r, lat);
    check("fwd_c1", r, VOUT);
    check("fwd_c1_lat", 128'(lat), 128'(5));
    xfer(2, VOUT, 2'd1, 0, r, lat);
    check("inv_c4", r, VIN);
    check("inv_c4_lat", 128'(lat), 128'(2));
    xfer(1, VOUT, 2'd1, 0, r, lat);
    check("inv_c2", r, VIN);
    check("inv_c2_lat", 128'(lat), 128'(3));
    for (int k = 0; k < 3; k++)
      for (int m = 2; m < 4; m++) begin
        xfer(k, BYP, 2'(m), 0, r, lat);
        check("bypass", r, BYP);
        check("bypass_lat", 128'(lat), 128'(1));
      end
    d1 = {$urandom, $urandom, $urandom, $urandom};
    d2 = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    in_valid[0] = 1; in_data[0] = d1; in_mode[0] = 2'd0;
    @(posedge clk);
    @(negedge clk);
    in_data[0] = d2;
    lat = 1;
    wait_out(0, lat);
    r = out_data[0];
    check("bp_first", r, model(d1, 2'd0));
    repeat (10) begin
      @(negedge clk);
      check("bp_data", out_data[0], r);
      check("bp_valid", 128'(out_valid[0]), 128'(1));
      check("bp_in_ready", 128'(in_ready[0]), 128'(0));
    end
    release_out(0);
    check("bp_idle_ready", 128'(in_ready[0]), 128'(1));
    check("bp_idle_valid", 128'(out_valid[0]), 128'(0));
    @(negedge clk);
    in_valid[0] = 0;
    check("bp_accepted", 128'(in_ready[0]), 128'(0));
    lat = 2;
    wait_out(0, lat);
    check("bp_second", out_data[0], model(d2, 2'd0));
    release_out(0);
    in_valid[0] = 1; in_data[0] = d1; in_mode[0] = 2'd0;
    @(posedge clk);
    @(negedge clk);
    in_valid[0] = 0;
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    check("midrst_valid", 128'(out_valid[0]), 128'(0));
    check("midrst_data", out_data[0], '0);
    check("midrst_ready", 128'(in_ready[0]), 128'(1));
    xfer(0, d2, 2'd1, 0, r, lat);
    check("midrst_fresh", r, model(d2, 2'd1));
    for (int i = 0; i < 1000; i++) begin
      int k;
      logic [1:0] m;
      k = $urandom_range(0, 2);
      m = 2'($urandom);
      d1 = {$urandom, $urandom, $urandom, $urandom};
      xfer(k, d1, m, 3, r, lat);
      check("rand_data", r, model(d1, m));
      check("rand_lat", 128'(lat), 128'(m[1] ? 1 : (4 >> k) + 1));
      if (m == 2'd0 && i % 3 == 0) begin
        xfer(k, r, 2'd1, 3, r2, lat);
        check("roundtrip", r2, d1);
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "timeout");
  end
endmodule
